// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/operand request and BCD result bundle for bin2bcd_seq
// (the e3 signal exists only when BIN2BCD_E3_OUT_EN is defined)
interface bin2bcd_seq_if #(
  parameter int BIN_W = 8,
  parameter int DIGITS = 3
);
  logic start;
  logic [BIN_W-1:0] bin;
  logic busy;
  logic done;
  logic [4*DIGITS-1:0] bcd;
  logic ovf;
`ifdef BIN2BCD_E3_OUT_EN
  logic [4*DIGITS-1:0] e3;
  modport master(output start, bin, input busy, done, bcd, ovf, e3);
  modport slave(input start, bin, output busy, done, bcd, ovf, e3);
`else
  modport master(output start, bin, input busy, done, bcd, ovf);
  modport slave(input start, bin, output busy, done, bcd, ovf);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock
// BIN2BCD_E3_OUT_EN adds a registered Excess-3 copy of the result on io.e3
module bin2bcd_seq #(
  parameter int BIN_W = 8,
  parameter int DIGITS = 3
) (
  input logic clk,
  input logic rst_n,
  bin2bcd_seq_if.slave io
);
  localparam int BW = 4 * DIGITS;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [BIN_W-1:0] shreg;
  logic [BW-1:0] scratch, adj, nxt, bcd;
  logic [5:0] cnt;
  logic sticky, busy, done, ovf;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign adj[4*d+:4] = scratch[4*d+:4] >= 4'd5 ? scratch[4*d+:4] + 4'd3 : scratch[4*d+:4];
  end
  assign nxt = {adj[BW-2:0], shreg[BIN_W-1]};
`ifdef BIN2BCD_E3_OUT_EN
  logic [BW-1:0] e3, e3_nxt;
  for (genvar d = 0; d < DIGITS; d++) begin : g_e3
    assign e3_nxt[4*d+:4] = nxt[4*d+:4] + 4'd3;
  end
  assign io.e3 = e3;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      scratch <= '0;
      cnt <= '0;
      sticky <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      bcd <= '0;
      ovf <= 1'b0;
`ifdef BIN2BCD_E3_OUT_EN
      e3 <= {DIGITS{4'h3}};
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (io.start) begin
          shreg <= io.bin;
          scratch <= '0;
          sticky <= 1'b0;
          cnt <= '0;
          busy <= 1'b1;
          state <= SHIFT;
        end
      end else begin
        // a set top bit after adjust is the digit that no longer fits
        scratch <= nxt;
        shreg <= shreg << 1;
        sticky <= sticky | adj[BW-1];
        cnt <= cnt + 6'd1;
        if (cnt == 6'(BIN_W - 1)) begin
          bcd <= nxt;
          ovf <= sticky | adj[BW-1];
`ifdef BIN2BCD_E3_OUT_EN
          e3 <= e3_nxt;
`endif
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
  assign io.busy = busy;
  assign io.done = done;
  assign io.bcd = bcd;
  assign io.ovf = ovf;
endmodule
